uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one Simple UART transmitter between N_REQ independent byte sources (debounced-button senders, status reporters, loopback echo).
- Round-robin arbitration; latches the winner's byte and frame config (stop-bit size, data size); issues a single-cycle send pulse; holds data and config stable until the UART returns to ready.
- Sits between the requesters and the UART tx instance; replaces direct send/data_i/stop_bit_size/data_size wiring on the board.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of grant_id; must equal clog2(N_REQ)
- BUSY_TIMEOUT, 15, cycles after tx_send to wait for tx_ready to fall before aborting

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  N_REQ  per-requester request; held high until acked
- req_data  in  8*N_REQ  requester i byte at [8i+7:8i]
- req_stop  in  N_REQ  per-requester stop-bit size (0 = 1 bit, 1 = 2 bits)
- req_len  in  N_REQ  per-requester data size (0 = 8 bit, 1 = 7 bit)
- req_ack  out  N_REQ  one-hot one-cycle pulse: request captured
- tx_ready  in  1  UART transmitter idle
- tx_send  out  1  one-cycle send strobe to UART
- tx_data  out  8  byte to UART
- tx_stop_bit_size  out  1  to UART stop_bit_size
- tx_data_size  out  1  to UART data_size
- grant_id  out  ID_W  index of the current or last granted requester
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse on busy-timeout abort

Behaviour:
- Reset: state IDLE; all outputs 0; rr pointer = 0 (requester 0 highest priority); timeout counter 0. Reset mid-transfer aborts immediately; no ack or send is issued afterwards.
- States: IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: if tx_ready=1 and any req_valid, go to LOAD next cycle. Winner is the first valid index searching ptr, ptr+1, ... modulo N_REQ. With tx_ready=0, wait in IDLE.
- IDLE->LOAD edge: register tx_data, tx_stop_bit_size, tx_data_size and grant_id from the winner.
  - If req_len=1, tx_data[7] is forced 0.
  - req_ack[winner] pulses in LOAD (one cycle).
  - ptr <= winner+1, wrapping at N_REQ-1 to 0.
- LOAD -> SEND unconditionally. tx_send=1 for exactly the SEND cycle; data and config are already stable for one cycle before it.
- SEND -> WAIT_BUSY; the timeout counter clears.
- WAIT_BUSY:
  - tx_ready=0 -> WAIT_DONE.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT, pulse timeout_err and go to IDLE. No retry; the request is already acked.
- WAIT_DONE: tx_ready=1 -> IDLE.
- tx_data, config and grant_id hold their values from LOAD through the return to IDLE, and also while in IDLE (not cleared).
- Latency: request seen in IDLE at cycle 0 -> ack at cycle 1 -> tx_send at cycle 2.
- Back-to-back: the earliest next LOAD is the cycle after returning to IDLE, giving one IDLE cycle minimum between frames.
- Request changes: a requester dropping req_valid before ack is simply not granted. Changes to req_* after ack have no effect on the current frame.
- Simultaneous requests: exactly one ack per arbitration. Losers stay pending and are never starved; worst-case wait is N_REQ-1 frames.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (S_IDLE..S_WAIT_DONE)
  - STOP_1/STOP_2 and LEN_8/LEN_7 constants
  - default BUSY_TIMEOUT
- One natural sub-module, rr_picker: combinational round-robin search over valid and ptr, returning winner index and any_valid.
- FSM, registers and counter remain in uart_tx_arbiter.

Test Plan:
- Single request: after reset, req_valid[2]=1, req_data[2]=8'hA5, stop=1, len=0, tx_ready=1.
  - Required: req_ack=4'b0100 at cycle 1.
  - Required: tx_send at cycle 2 with tx_data=A5, tx_stop_bit_size=1, tx_data_size=0, grant_id=2.
- Round robin: all four valid continuously, model UART drops ready for 20 cycles per send.
  - Required: grant order 0,1,2,3,0,1.
  - Required: exactly one req_ack bit per frame.
- 7-bit mask: req_len[1]=1, req_data[1]=8'hFF. Required: tx_data=8'h7F, tx_data_size=1.
- Timeout: tx_ready held 1 after send.
  - Required: timeout_err pulses 15 cycles after entering WAIT_BUSY.
  - Required: return to IDLE; next request is served normally.
- Reset mid-frame: rst=1 during WAIT_DONE.
  - Required next cycle: state IDLE and busy=0.
  - Required next cycle: tx_send=0, tx_data=0, tx_stop_bit_size=0, tx_data_size=0, grant_id=0, req_ack=0, timeout_err=0, ptr=0.
- Ready gating: tx_ready=0 in IDLE with req_valid[0]=1.
  - Required: no ack while tx_ready is 0.
  - Required: ack one cycle after tx_ready rises.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit arbiter: FSM states, frame-config
// constants and the default busy-timeout.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;
  localparam logic LEN_8  = 1'b0;
  localparam logic LEN_7  = 1'b1;

  localparam int DEF_BUSY_TIMEOUT = 15;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first valid index starting at ptr,
// wrapping modulo N_REQ.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any_valid
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (valid[idx]) begin
        any_valid = 1'b1;
        winner    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources;
// latches the winner's byte and frame config and strobes a single send.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int ID_W         = 2,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_stop,
  input  logic [N_REQ-1:0]     req_len,
  output logic [N_REQ-1:0]     req_ack,
  input  logic                 tx_ready,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  output logic                 tx_stop_bit_size,
  output logic                 tx_data_size,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  winner;
  logic             any_valid;
  logic [7:0]       win_byte;
  logic             win_len7;

  rr_picker #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .valid    (req_valid),
    .ptr      (ptr),
    .winner   (winner),
    .any_valid(any_valid)
  );

  // 7-bit frames never carry bit 7, so it is cleared before it reaches the UART.
  assign win_byte = req_data[{winner, 3'b000} +: 8];
  assign win_len7 = (req_len[winner] == LEN_7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      ptr              <= '0;
      cnt              <= '0;
      req_ack          <= '0;
      tx_send          <= 1'b0;
      tx_data          <= '0;
      tx_stop_bit_size <= 1'b0;
      tx_data_size     <= 1'b0;
      grant_id         <= '0;
      busy             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      req_ack     <= '0;
      tx_send     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_ready && any_valid) begin
            state            <= S_LOAD;
            busy             <= 1'b1;
            tx_data          <= {win_byte[7] & ~win_len7, win_byte[6:0]};
            tx_stop_bit_size <= req_stop[winner];
            tx_data_size     <= req_len[winner];
            grant_id         <= winner;
            req_ack          <= N_REQ'(1) << winner;
            ptr              <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        S_LOAD: begin
          state   <= S_SEND;
          tx_send <= 1'b1;
        end
        S_SEND: begin
          state <= S_WAIT_BUSY;
          cnt   <= '0;
        end
        // A UART that never leaves ready is abandoned; the request stays acked.
        S_WAIT_BUSY: begin
          if (!tx_ready) begin
            state <= S_WAIT_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              state       <= S_IDLE;
              busy        <= 1'b0;
            end
          end
        end
        S_WAIT_DONE: begin
          if (tx_ready) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple UART ready model.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       len;
    logic [1:0] id;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_stop = '0;
  logic [N-1:0] req_len = '0;
  logic [N-1:0] req_ack;
  logic         tx_ready;
  logic         tx_send;
  logic [7:0]   tx_data;
  logic         tx_stop_bit_size;
  logic         tx_data_size;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  // mode 0: tx_ready = ready_level; mode 1: UART model drops ready 20 cycles per send
  int   mode = 0;
  logic ready_level = 1'b1;
  logic model_ready = 1'b1;
  int   model_busy = 0;

  assign tx_ready = (mode == 0) ? ready_level : model_ready;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .ID_W(2), .BUSY_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_stop(req_stop), .req_len(req_len), .req_ack(req_ack),
    .tx_ready(tx_ready), .tx_send(tx_send), .tx_data(tx_data),
    .tx_stop_bit_size(tx_stop_bit_size), .tx_data_size(tx_data_size),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always @(posedge clk) begin
    #1;
    if (mode == 0) begin
      model_busy  = 0;
      model_ready = 1'b1;
    end else if (tx_send) begin
      model_busy  = 20;
      model_ready = 1'b0;
    end else if (model_busy > 0) begin
      model_busy = model_busy - 1;
      if (model_busy == 0) model_ready = 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    mode = 0;
    ready_level = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_stop = '0;
    req_len = '0;
    sb.delete();
    tick;
    tick;
    rst = 1'b0;
    mode = 1;
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick;
      if (tx_send) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    checks++;
    if ({tx_send, tx_data, tx_stop_bit_size, tx_data_size, grant_id, busy, timeout_err} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got send=%b data=%h stop=%b size=%b id=%0d busy=%b to=%b, need all 0",
               tx_send, tx_data, tx_stop_bit_size, tx_data_size, grant_id, busy, timeout_err);
    end
    checks++;
    if (req_ack !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ack: got %b need 0000", req_ack);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    bit ok;
    do_reset;
    req_valid = 4'b0100;
    req_data[8*2 +: 8] = 8'hA5;
    req_stop = 4'b0100;
    req_len = 4'b0000;
    sb.push_back('{data: 8'hA5, stop: 1'b1, len: 1'b0, id: 2'd2});
    tick;
    checks++;
    if (req_ack !== 4'b0100) begin
      failures++;
      $display("FAIL single_ack_cycle1: got %b need 0100", req_ack);
    end
    req_valid = '0;
    tick;
    checks++;
    if (tx_send !== 1'b1) begin
      failures++;
      $display("FAIL single_send_cycle2: got %b need 1", tx_send);
    end
    e = sb.pop_front();
    checks++;
    if ({tx_data, tx_stop_bit_size, tx_data_size, grant_id} !== e) begin
      failures++;
      $display("FAIL single_frame: got data=%h stop=%b size=%b id=%0d need data=%h stop=%b size=%b id=%0d",
               tx_data, tx_stop_bit_size, tx_data_size, grant_id, e.data, e.stop, e.len, e.id);
    end
    tick;
    checks++;
    if (tx_send !== 1'b0) begin
      failures++;
      $display("FAIL single_send_width: got %b need 0", tx_send);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_idle: busy stuck at %b need 0", busy);
    end
  endtask

  task automatic test_round_robin;
    exp_t e;
    bit ok;
    int sends;
    int acks;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    do_reset;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
    req_stop = 4'b1010;
    req_len = 4'b0000;
    for (int j = 0; j < 6; j++)
      sb.push_back('{data: 8'h10 + 8'(order[j]), stop: req_stop[order[j]], len: 1'b0, id: 2'(order[j])});
    req_valid = 4'b1111;
    sends = 0;
    acks = 0;
    for (int k = 0; k < 1000 && sends < 6; k++) begin
      tick;
      if (req_ack !== 4'b0000) begin
        acks++;
        checks++;
        if (!$onehot(req_ack) || sb.size() == 0 || req_ack !== (4'b0001 << sb[0].id)) begin
          failures++;
          $display("FAIL rr_ack: got %b need one-hot for id %0d", req_ack, sb.size() ? sb[0].id : 2'd0);
        end
      end
      if (tx_send) begin
        sends++;
        e = sb.pop_front();
        checks++;
        if ({tx_data, tx_stop_bit_size, tx_data_size, grant_id} !== e) begin
          failures++;
          $display("FAIL rr_frame%0d: got data=%h stop=%b id=%0d need data=%h stop=%b id=%0d",
                   sends, tx_data, tx_stop_bit_size, grant_id, e.data, e.stop, e.id);
        end
      end
    end
    req_valid = '0;
    checks++;
    if (sends != 6 || acks != 6) begin
      failures++;
      $display("FAIL rr_counts: got sends=%0d acks=%0d need 6 and 6", sends, acks);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_idle: busy stuck at %b need 0", busy);
    end
  endtask

  task automatic test_len7;
    exp_t e;
    bit ok;
    do_reset;
    req_data[8*1 +: 8] = 8'hFF;
    req_len = 4'b0010;
    req_stop = 4'b0000;
    req_valid = 4'b0010;
    sb.push_back('{data: 8'h7F, stop: 1'b0, len: 1'b1, id: 2'd1});
    tick;
    // changes after the ack must not reach the current frame
    req_valid = '0;
    req_data[8*1 +: 8] = 8'h00;
    req_len = 4'b0000;
    tick;
    checks++;
    if (tx_send !== 1'b1) begin
      failures++;
      $display("FAIL len7_send: got %b need 1", tx_send);
    end
    e = sb.pop_front();
    checks++;
    if ({tx_data, tx_stop_bit_size, tx_data_size, grant_id} !== e) begin
      failures++;
      $display("FAIL len7_frame: got data=%h size=%b id=%0d need data=%h size=%b id=%0d",
               tx_data, tx_data_size, grant_id, e.data, e.len, e.id);
    end
    wait_idle(ok);
  endtask

  task automatic test_timeout;
    exp_t e;
    bit ok;
    int hit;
    do_reset;
    mode = 0;
    ready_level = 1'b1;
    req_data[8*3 +: 8] = 8'h3C;
    req_valid = 4'b1000;
    wait_send(ok);
    req_valid = '0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_send: tx_send not seen, got %b need 1", tx_send);
    end
    hit = -1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (timeout_err) begin
        hit = k;
        break;
      end
    end
    checks++;
    if (hit != 16) begin
      failures++;
      $display("FAIL timeout_cycle: got pulse %0d cycles after send need 16", hit);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: busy got %b need 0", busy);
    end
    tick;
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width: got %b need 0", timeout_err);
    end
    mode = 1;
    req_data[8*0 +: 8] = 8'h5A;
    req_valid = 4'b0001;
    sb.push_back('{data: 8'h5A, stop: 1'b0, len: 1'b0, id: 2'd0});
    tick;
    checks++;
    if (req_ack !== 4'b0001) begin
      failures++;
      $display("FAIL timeout_next_ack: got %b need 0001", req_ack);
    end
    req_valid = '0;
    tick;
    e = sb.pop_front();
    checks++;
    if ({tx_send, tx_data, grant_id} !== {1'b1, e.data, e.id}) begin
      failures++;
      $display("FAIL timeout_next_frame: got send=%b data=%h id=%0d need send=1 data=%h id=%0d",
               tx_send, tx_data, grant_id, e.data, e.id);
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit ok;
    do_reset;
    req_data[8*2 +: 8] = 8'h99;
    req_stop = 4'b0100;
    req_len = 4'b0100;
    req_valid = 4'b0100;
    sb.push_back('{data: 8'h19, stop: 1'b1, len: 1'b1, id: 2'd2});
    wait_send(ok);
    req_valid = '0;
    e = sb.pop_front();
    checks++;
    if (!ok || {tx_data, tx_stop_bit_size, tx_data_size, grant_id} !== e) begin
      failures++;
      $display("FAIL mid_frame: got data=%h stop=%b size=%b id=%0d need data=%h stop=%b size=%b id=%0d",
               tx_data, tx_stop_bit_size, tx_data_size, grant_id, e.data, e.stop, e.len, e.id);
    end
    tick;
    tick;
    tick;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_in_frame: busy got %b need 1", busy);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({busy, tx_send, tx_data, tx_stop_bit_size, tx_data_size, grant_id, req_ack, timeout_err} !== 19'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got busy=%b send=%b data=%h stop=%b size=%b id=%0d ack=%b to=%b need all 0",
               busy, tx_send, tx_data, tx_stop_bit_size, tx_data_size, grant_id, req_ack, timeout_err);
    end
    mode = 0;
    ready_level = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if ({tx_send, req_ack} !== 5'd0) begin
        failures++;
        $display("FAIL mid_no_resend: got send=%b ack=%b need 0 and 0000", tx_send, req_ack);
      end
    end
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'hC0 + 8'(i);
    req_stop = '0;
    req_len = '0;
    req_valid = 4'b1111;
    sb.push_back('{data: 8'hC0, stop: 1'b0, len: 1'b0, id: 2'd0});
    tick;
    req_valid = '0;
    mode = 1;
    checks++;
    if (req_ack !== 4'b0001) begin
      failures++;
      $display("FAIL mid_ptr_reset: got ack %b need 0001", req_ack);
    end
    tick;
    e = sb.pop_front();
    checks++;
    if ({tx_send, tx_data, grant_id} !== {1'b1, e.data, e.id}) begin
      failures++;
      $display("FAIL mid_after_frame: got send=%b data=%h id=%0d need send=1 data=%h id=%0d",
               tx_send, tx_data, grant_id, e.data, e.id);
    end
    wait_idle(ok);
  endtask

  task automatic test_ready_gating;
    exp_t e;
    bit ok;
    do_reset;
    mode = 0;
    ready_level = 1'b0;
    req_data[8*0 +: 8] = 8'h42;
    req_valid = 4'b0001;
    sb.push_back('{data: 8'h42, stop: 1'b0, len: 1'b0, id: 2'd0});
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++;
      if ({req_ack, busy} !== 5'd0) begin
        failures++;
        $display("FAIL gate_hold: got ack=%b busy=%b need 0000 and 0", req_ack, busy);
      end
    end
    ready_level = 1'b1;
    tick;
    checks++;
    if (req_ack !== 4'b0001) begin
      failures++;
      $display("FAIL gate_ack: got %b need 0001", req_ack);
    end
    req_valid = '0;
    mode = 1;
    tick;
    e = sb.pop_front();
    checks++;
    if ({tx_send, tx_data, grant_id} !== {1'b1, e.data, e.id}) begin
      failures++;
      $display("FAIL gate_frame: got send=%b data=%h id=%0d need send=1 data=%h id=%0d",
               tx_send, tx_data, grant_id, e.data, e.id);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL gate_idle: busy stuck at %b need 0", busy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_len7;
    test_timeout;
    test_reset_mid;
    test_ready_gating;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
